dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory port: accepts one read or write request at a time over a valid/ready handshake.
- Services each request from an internal DEPTH x DATA_W register array after a programmable number of wait states.
- Returns a one-cycle response pulse carrying read data.
- Sits between the processor core's load/store path and backing storage; gives the multi-cycle core variant a memory with realistic latency in place of the single-cycle RAM macro.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a fixed number of wait states.
// It accepts one read or write at a time over a valid/ready handshake and
// services it from an internal DEPTH x DATA_W register array. Each access
// ends with a single-cycle response pulse.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to flag any request with
// req_addr >= DEPTH. Such a request still completes with normal latency, but
// it does not write the array, returns zero read data and raises resp_err.
// Without the macro, addresses wrap modulo DEPTH and resp_err is tied to 0.
//
// Ports:
//   clk, resetBar              clock (rising edge), async active-low reset
//   req_valid / req_ready      request handshake
//   req_wren, req_addr,        request: 1 = write, word address,
//   req_wdata                  and write data
//   resp_valid                 one-cycle response pulse
//   resp_rdata                 read data (the written data for writes)
//   resp_err                   out-of-range flag (range-check build only)
//   busy                       a transaction is in flight
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetBar,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept_c;
  logic              access_c;
  logic              acc_wren_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic [IDX_W-1:0]  idx_c;
  logic              oob_c;
  logic              mem_we_c;

  // Access edge decode: with zero wait states the access happens on the
  // acceptance edge itself, so it uses the live request rather than the
  // latched copy.
  always_comb begin
    accept_c    = (state == ST_IDLE) && req_valid;
    access_c    = ((state == ST_WAIT) && (cnt == '0)) ||
                  (accept_c && (WAIT_CYCLES == 0));
    acc_wren_c  = (state == ST_IDLE) ? req_wren  : wren_q;
    acc_addr_c  = (state == ST_IDLE) ? req_addr  : addr_q;
    acc_wdata_c = (state == ST_IDLE) ? req_wdata : wdata_q;
    idx_c       = acc_addr_c[IDX_W-1:0];
    oob_c       = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oob_c       = ({1'b0, acc_addr_c} >= (ADDR_W+1)'(DEPTH));
`endif
    mem_we_c    = access_c && acc_wren_c && !oob_c;
  end

  // Storage array. It is not reset; an abandoned write never reaches it
  // because reset forces the FSM back to idle first.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= acc_wdata_c;
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Transaction FSM; all handshake and response outputs are registered.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      busy       <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            wren_q    <= req_wren;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
          err_q      <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase

      // Response data is captured on the access edge and then held
      // until the next access.
      if (access_c) begin
        if (oob_c)           resp_rdata <= '0;
        else if (acc_wren_c) resp_rdata <= acc_wdata_c;
        else                 resp_rdata <= mem[idx_c];
`ifdef DMEM_RANGE_CHECK_EN
        err_q <= oob_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder. It drives three
// instances with different settings:
//   d0: WAIT_CYCLES = 2, DEPTH = 256
//   d1: WAIT_CYCLES = 0, DEPTH = 16
//   d2: WAIT_CYCLES = 4, DEPTH = 256
// Expected values come from a per-instance array model.
module tb_dmem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid  [3];
  logic       req_ready  [3];
  logic       req_wren   [3];
  logic [7:0] req_addr   [3];
  logic [7:0] req_wdata  [3];
  logic       resp_valid [3];
  logic [7:0] resp_rdata [3];
  logic       resp_err   [3];
  logic       busy       [3];

  logic [7:0] mdl [3][256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_d0 (
    .clk(clk), .resetBar(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wren(req_wren[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]));
  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_d1 (
    .clk(clk), .resetBar(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wren(req_wren[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]));
  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(4)) u_d2 (
    .clk(clk), .resetBar(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wren(req_wren[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
    .busy(busy[2]));

  function automatic int wait_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  function automatic int depth_of(input int d);
    return (d == 1) ? 16 : 256;
  endfunction

  // True when the address is flagged as out of range in this build.
  function automatic bit oob_of(input int d, input logic [7:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return int'(a) >= depth_of(d);
`else
    return (d < 0) && (a == 8'h00);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request until it is accepted, then drops valid and scrambles
  // the request fields so that any late use of them is exposed.
  task automatic send(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd);
    logic rdy;
    bit   ok;
    ok           = 1'b0;
    req_valid[d] = 1'b1;
    req_wren[d]  = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    for (int n = 0; n < 50; n++) begin
      rdy = req_ready[d];
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 1);
    req_valid[d] = 1'b0;
    req_wren[d]  = 1'($urandom);
    req_addr[d]  = 8'($urandom);
    req_wdata[d] = 8'($urandom);
  endtask

  // Waits for the response pulse and checks its latency, data and duration.
  // The call starts one sample after acceptance.
  task automatic finish_resp(input int d, input int lat, input logic [7:0] er, input logic ee);
    int n;
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 40) begin
      chk("busy_hold", 32'(busy[d]), 1);
      chk("ready_low", 32'(req_ready[d]), 0);
      chk("err_idle", 32'(resp_err[d]), 0);
      step();
      n++;
    end
    chk("latency", n, lat);
    chk("rdata", 32'(resp_rdata[d]), 32'(er));
    chk("err", 32'(resp_err[d]), 32'(ee));
    chk("ready_resp", 32'(req_ready[d]), 0);
    step();
    chk("pulse_one", 32'(resp_valid[d]), 0);
    chk("ready_back", 32'(req_ready[d]), 1);
    chk("busy_clear", 32'(busy[d]), 0);
    chk("err_clear", 32'(resp_err[d]), 0);
    chk("rdata_hold", 32'(resp_rdata[d]), 32'(er));
  endtask

  // Runs a full transaction and checks it against the array model.
  task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd);
    int         idx;
    bit         oob;
    logic [7:0] er;
    idx = int'(a) % depth_of(d);
    oob = oob_of(d, a);
    if (oob)       er = 8'h00;
    else if (w)    er = wd;
    else           er = mdl[d][idx];
    if (w && !oob) mdl[d][idx] = wd;
    send(d, w, a, wd);
    finish_resp(d, wait_of(d), er, oob);
  endtask

  task automatic check_idle_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_ready"}, 32'(req_ready[d]), 1);
      chk({tag, "_valid"}, 32'(resp_valid[d]), 0);
      chk({tag, "_busy"}, 32'(busy[d]), 0);
      chk({tag, "_err"}, 32'(resp_err[d]), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rdy;
    int         k;
    logic [7:0] a;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_wren[d]  = 1'b0;
      req_addr[d]  = 8'h00;
      req_wdata[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_all("in_reset");
    for (int d = 0; d < 3; d++) chk("reset_rdata", 32'(resp_rdata[d]), 0);
    rst_n = 1'b1;
    step();
    check_idle_all("after_reset");

    // Write, read-back, and neighbouring-word independence.
    txn(0, 1'b1, 8'h10, 8'hA5);
    txn(0, 1'b0, 8'h10, 8'h00);
    txn(0, 1'b1, 8'h11, 8'h3C);
    txn(0, 1'b0, 8'h11, 8'h00);
    txn(0, 1'b0, 8'h10, 8'h00);

    // Fill the words that the random phase reads.
    for (int i = 0; i < 32; i++) txn(0, 1'b1, 8'(i), 8'($urandom));
    for (int i = 0; i < 16; i++) txn(1, 1'b1, 8'(i), 8'($urandom));
    for (int i = 0; i < 32; i++) txn(2, 1'b1, 8'(i), 8'($urandom));

    // Zero wait states with valid held high: one acceptance every other cycle.
    k = 0;
    req_valid[1] = 1'b1;
    req_wren[1]  = 1'b1;
    req_addr[1]  = 8'h00;
    req_wdata[1] = 8'h40;
    for (int c = 0; c < 8; c++) begin
      rdy = req_ready[1];
      step();
      if (rdy) begin
        chk("b2b_valid", 32'(resp_valid[1]), 1);
        chk("b2b_rdata", 32'(resp_rdata[1]), 32'h40 + 32'(k));
        mdl[1][k] = 8'(8'h40 + k);
        k++;
        req_addr[1]  = 8'(k);
        req_wdata[1] = 8'(8'h40 + k);
      end else begin
        chk("b2b_gap", 32'(resp_valid[1]), 0);
      end
    end
    chk("b2b_count", k, 4);
    req_valid[1] = 1'b0;
    step();
    txn(1, 1'b0, 8'h02, 8'h00);

    // Wrap-around in the default build, or a range error with the macro.
    txn(1, 1'b1, 8'h13, 8'h77);
    txn(1, 1'b0, 8'h03, 8'h00);

    // Reset during wait states: the response and the pending write are dropped.
    txn(2, 1'b1, 8'h20, 8'h00);
    send(2, 1'b1, 8'h20, 8'hFF);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready[2]), 1);
    chk("midrst_busy", 32'(busy[2]), 0);
    chk("midrst_valid", 32'(resp_valid[2]), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("midrst_no_resp", 32'(resp_valid[2]), 0);
    end
    txn(2, 1'b0, 8'h20, 8'h00);

    // Request changes and a valid pulse while busy must have no effect.
    send(0, 1'b1, 8'h30, 8'h5A);
    mdl[0][8'h30] = 8'h5A;
    req_valid[0] = 1'b1;
    req_wren[0]  = 1'b0;
    req_addr[0]  = 8'h10;
    step();
    req_valid[0] = 1'b0;
    finish_resp(0, wait_of(0) - 1, 8'h5A, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("no_extra_resp", 32'(resp_valid[0]), 0);
    end
    txn(0, 1'b0, 8'h30, 8'h00);

    // Random mix of reads and writes on every instance.
    for (int i = 0; i < 60; i++) begin
      int d;
      d = i % 3;
      a = (d == 1) ? 8'($urandom) : 8'($urandom_range(0, 31));
      txn(d, 1'($urandom), a, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
